// File: rtl/maxpool_scheduler.sv
// Sweeps a feature map in 2x2 windows, feeding a max-pool unit
// and writing each pooled result to the output buffer.
module maxpool_scheduler #(
   parameter int DATA_W  = 22,
   parameter int IMG_W   = 4,
   parameter int IMG_H   = 4,
   parameter int IN_AW   = 4,
   parameter int OUT_AW  = 2,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              rd_en,
   output logic [IN_AW-1:0]  rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] pool_in1,
   output logic [DATA_W-1:0] pool_in2,
   output logic [DATA_W-1:0] pool_in3,
   output logic [DATA_W-1:0] pool_in4,
   output logic              pool_en,
   input  logic              pool_done,
   input  logic [DATA_W-1:0] pool_out,
   output logic              wr_en,
   output logic [OUT_AW-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int WR_ROWS = IMG_H / 2;
   localparam int WC_COLS = IMG_W / 2;
   localparam int RW = (WR_ROWS > 1) ? $clog2(WR_ROWS) : 1;
   localparam int CW = (WC_COLS > 1) ? $clog2(WC_COLS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [RW-1:0] R_LAST = RW'(WR_ROWS - 1);
   localparam logic [CW-1:0] C_LAST = CW'(WC_COLS - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   localparam logic [IN_AW-1:0] A_ONE  = IN_AW'(1);
   localparam logic [IN_AW-1:0] A_ROW  = IN_AW'(IMG_W);
   localparam logic [IN_AW-1:0] A_ROW1 = IN_AW'(IMG_W + 1);
   localparam logic [IN_AW-1:0] A_COL  = IN_AW'(2);
   // Jump from the last window of a row to the first of the next pair of rows
   localparam logic [IN_AW-1:0] A_NXT  = IN_AW'(2 * IMG_W - 2 * (WC_COLS - 1));

   typedef enum logic [3:0] {
      IDLE, RD0, RD1, RD2, RD3, CAP, POOL, WAIT, WR, FIN
   } state_t;

   state_t state, nxt;

   logic [RW-1:0]     row;
   logic [CW-1:0]     col;
   logic [IN_AW-1:0]  base;
   logic [OUT_AW-1:0] widx;
   logic [TW-1:0]     tmo;
   logic              last;

   assign last = (row == R_LAST) && (col == C_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt     = state;
      busy    = (state != IDLE);
      done    = 1'b0;
      rd_en   = 1'b0;
      rd_addr = '0;
      pool_en = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      unique case (state)
         IDLE: if (start) nxt = RD0;
         RD0: begin
            rd_en   = 1'b1;
            rd_addr = base;
            nxt     = RD1;
         end
         RD1: begin
            rd_en   = 1'b1;
            rd_addr = base + A_ONE;
            nxt     = RD2;
         end
         RD2: begin
            rd_en   = 1'b1;
            rd_addr = base + A_ROW;
            nxt     = RD3;
         end
         RD3: begin
            rd_en   = 1'b1;
            rd_addr = base + A_ROW1;
            nxt     = CAP;
         end
         CAP: nxt = POOL;
         POOL: begin
            pool_en = 1'b1;
            nxt     = WAIT;
         end
         WAIT: begin
            if (pool_done)         nxt = WR;
            else if (tmo == T_LAST) nxt = FIN;
         end
         WR: begin
            wr_en   = 1'b1;
            wr_addr = widx;
            nxt     = last ? FIN : RD0;
         end
         FIN: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err      <= 1'b0;
         row      <= '0;
         col      <= '0;
         base     <= '0;
         widx     <= '0;
         tmo      <= '0;
         pool_in1 <= '0;
         pool_in2 <= '0;
         pool_in3 <= '0;
         pool_in4 <= '0;
         wr_data  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               err  <= 1'b0;
               row  <= '0;
               col  <= '0;
               base <= '0;
               widx <= '0;
            end
            RD1:  pool_in1 <= rd_data;
            RD2:  pool_in2 <= rd_data;
            RD3:  pool_in3 <= rd_data;
            CAP:  pool_in4 <= rd_data;
            POOL: tmo <= '0;
            WAIT: begin
               if (pool_done)          wr_data <= pool_out;
               else if (tmo == T_LAST) err <= 1'b1;
               else                    tmo <= tmo + 1'b1;
            end
            WR: if (!last) begin
               widx <= widx + 1'b1;
               if (col == C_LAST) begin
                  col  <= '0;
                  row  <= row + 1'b1;
                  base <= base + A_NXT;
               end else begin
                  col  <= col + 1'b1;
                  base <= base + A_COL;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Scoreboard bench for maxpool_scheduler: RAM and pool-unit models,
// directed passes with hand-computed window contents and results.
module tb_maxpool_scheduler;

   localparam int DW = 22;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, err, rd_en, pool_en, wr_en;
   logic [3:0]    rd_addr;
   logic [DW-1:0] rd_data = '0;
   logic [DW-1:0] pool_in1, pool_in2, pool_in3, pool_in4;
   logic          pool_done;
   logic [DW-1:0] pool_out;
   logic [1:0]    wr_addr;
   logic [DW-1:0] wr_data;

   maxpool_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy), .done(done), .err(err),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .pool_in1(pool_in1), .pool_in2(pool_in2),
      .pool_in3(pool_in3), .pool_in4(pool_in4),
      .pool_en(pool_en), .pool_done(pool_done), .pool_out(pool_out),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [16];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int checks = 0;
   int fails = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int pe_cnt = 0;
   int pool_delay = 1;
   int pend = 0;

   int              exp_addr[$];
   logic [DW-1:0]   exp_data[$];
   logic [4*DW-1:0] exp_pix[$];
   logic [4*DW-1:0] snap;
   bit              snap_v = 0;

   wire [4*DW-1:0] pix = {pool_in1, pool_in2, pool_in3, pool_in4};

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
      logic [DW-1:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // pooling unit: pool_done pool_delay cycles after pool_en (0 = never)
   initial begin
      pool_done = 1'b0;
      pool_out  = '0;
      forever begin
         @(negedge clk);
         pool_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) pool_done = 1'b1;
         end
         if (rst_n && pool_en && pool_delay > 0) begin
            pool_out = max4(pool_in1, pool_in2, pool_in3, pool_in4);
            pend = pool_delay;
         end
      end
   end

   always @(negedge clk) if (rst_n) begin
      if (done) done_cnt++;
      if (pool_en) begin
         pe_cnt++;
         if (exp_pix.size() == 0) chk("pool_extra", 1, 0);
         else chk("pool_in_order", pix, exp_pix.pop_front());
         snap = pix;
         snap_v = 1;
      end else if (snap_v) begin
         chk("pool_in_stable", pix, snap);
      end
      if (wr_en) begin
         wr_cnt++;
         if (exp_addr.size() == 0) chk("wr_extra", 1, 0);
         else begin
            chk("wr_addr", wr_addr, exp_addr.pop_front());
            chk("wr_data", wr_data, exp_data.pop_front());
         end
         snap_v = 0;
      end
      if (done) snap_v = 0;
   end

   task automatic load_std();
      for (int i = 0; i < 16; i++) mem[i] = DW'(i);
   endtask

   task automatic load_corner();
      for (int i = 0; i < 16; i++) mem[i] = DW'(i);
      mem[0] = 22'd100;
      mem[3] = 22'd100;
      mem[12] = 22'd100;
      mem[15] = 22'd100;
   endtask

   task automatic push_std();
      exp_pix.push_back({22'd0, 22'd1, 22'd4, 22'd5});
      exp_pix.push_back({22'd2, 22'd3, 22'd6, 22'd7});
      exp_pix.push_back({22'd8, 22'd9, 22'd12, 22'd13});
      exp_pix.push_back({22'd10, 22'd11, 22'd14, 22'd15});
      exp_data.push_back(22'd5);
      exp_data.push_back(22'd7);
      exp_data.push_back(22'd13);
      exp_data.push_back(22'd15);
      for (int i = 0; i < 4; i++) exp_addr.push_back(i);
   endtask

   task automatic push_corner();
      exp_pix.push_back({22'd100, 22'd1, 22'd4, 22'd5});
      exp_pix.push_back({22'd2, 22'd100, 22'd6, 22'd7});
      exp_pix.push_back({22'd8, 22'd9, 22'd100, 22'd13});
      exp_pix.push_back({22'd10, 22'd11, 22'd14, 22'd100});
      for (int i = 0; i < 4; i++) begin
         exp_addr.push_back(i);
         exp_data.push_back(22'd100);
      end
   endtask

   // cyc counts cycles from the first busy cycle (=1) to the done cycle
   task automatic run_pass(input int exp_lat, input bit exp_err,
                           input int exp_wr, input bit hold,
                           input int pulse_at);
      int w0, d0, cyc;
      bit busy_ok, seen, err1;
      w0 = wr_cnt;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      busy_ok = 1;
      seen = 0;
      err1 = 1;
      while (cyc < 600 && !seen) begin
         @(negedge clk);
         cyc++;
         start = hold || (cyc == pulse_at);
         if (cyc == 1) err1 = err;
         if (!busy) busy_ok = 0;
         if (done) seen = 1;
      end
      start = 1'b0;
      chk("done_seen", seen, 1);
      chk("latency", cyc, exp_lat);
      chk("busy_hold", busy_ok, 1);
      chk("err_clear", err1, 0);
      chk("err_at_done", err, exp_err);
      repeat (3) @(negedge clk);
      chk("idle_after", busy, 0);
      chk("err_sticky", err, exp_err);
      chk("wr_count", wr_cnt - w0, exp_wr);
      chk("done_count", done_cnt - d0, 1);
      chk("exp_left", exp_addr.size() + exp_pix.size(), 0);
   endtask

   initial begin
      int w0, d0, p0, n;
      load_std();
      #2;
      chk("rst_ctl", {busy, done, err, rd_en, pool_en, wr_en}, 0);
      chk("rst_addr", {rd_addr, wr_addr}, 0);
      chk("rst_pix", pix, 0);
      chk("rst_wdata", wr_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      pool_delay = 1;
      push_std();
      run_pass(33, 0, 4, 0, 0);

      pool_delay = 10;
      push_std();
      run_pass(69, 0, 4, 0, 0);

      pool_delay = 1;
      load_corner();
      push_corner();
      run_pass(33, 0, 4, 0, 0);

      // pool unit never answers: first window aborts
      load_std();
      pool_delay = 0;
      exp_pix.push_back({22'd0, 22'd1, 22'd4, 22'd5});
      run_pass(262, 1, 0, 0, 0);
      pool_delay = 1;
      push_std();
      run_pass(33, 0, 4, 0, 0);

      // reset in the second window's WAIT
      pool_delay = 10;
      push_std();
      w0 = wr_cnt;
      d0 = done_cnt;
      p0 = pe_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (pe_cnt < p0 + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_win2", pe_cnt - p0, 2);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ctl", {busy, done, err, rd_en, pool_en, wr_en}, 0);
      chk("mid_rst_addr", {rd_addr, wr_addr}, 0);
      chk("mid_rst_pix", pix, 0);
      chk("mid_rst_wdata", wr_data, 0);
      exp_addr.delete();
      exp_data.delete();
      exp_pix.delete();
      pend = 0;
      snap_v = 0;
      repeat (4) @(negedge clk);
      chk("rst_no_done", done_cnt - d0, 0);
      chk("rst_partial_wr", wr_cnt - w0, 1);
      rst_n = 1'b1;
      pool_delay = 1;
      @(negedge clk);
      push_std();
      run_pass(33, 0, 4, 0, 0);

      // start held through a pass, then a re-pulse mid-pass
      push_std();
      run_pass(33, 0, 4, 1, 0);
      push_std();
      run_pass(33, 0, 4, 0, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
